// File: rtl/wb_host_pkg.sv
// Shared types and defaults for the Wishbone host initiator.
// The response struct fixes the beat-count width; LEN_W on the top must match LEN_W_DEF.
package wb_host_pkg;

  localparam int ADR_STRIDE_DEF = 4;
  localparam int TO_CYC_DEF     = 255;
  localparam int LEN_W_DEF      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WFETCH,
    ST_STROBE,
    ST_RDRAIN,
    ST_GAP,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                 err;
    logic [LEN_W_DEF:0]   beats;
  } rsp_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Strobe watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches TO_CYC.
module wb_timeout_ctr #(
  parameter int TO_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] TOP  = CW'(TO_CYC);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != TOP) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Expiry is flagged in the TO_CYC-th enabled cycle so the strobe lasts exactly TO_CYC cycles.
  assign expired_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_host_initiator.sv
// Wishbone classic master: turns a command plus write/read data streams into
// single-beat bus cycles with auto-incrementing address and a strobe timeout.
module wb_host_initiator
  import wb_host_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int TO_CYC     = TO_CYC_DEF,
  parameter int ADR_STRIDE = ADR_STRIDE_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [3:0]        cmd_sel,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_err,
  output logic [LEN_W:0]    rsp_beats,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic [DATA_W-1:0] wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              busy
);

  localparam logic [LEN_W:0]    BEAT_ONE = (LEN_W+1)'(1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADR_STRIDE);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [3:0]          sel_q, sel_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  rsp_t                rsp_q, rsp_d;
  logic                to_clr, to_en, to_expired;

  wb_timeout_ctr #(
    .TO_CYC(TO_CYC)
  ) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (to_clr),
    .en_i     (to_en),
    .expired_o(to_expired)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    len_d       = len_q;
    dat_d       = dat_q;
    rdata_d     = rdata_q;
    rsp_d       = rsp_q;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rsp_valid   = 1'b0;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    to_clr      = 1'b0;
    to_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          sel_d   = cmd_sel;
          len_d   = cmd_len;
          rsp_d   = '0;
          to_clr  = 1'b1;
          state_d = cmd_we ? ST_WFETCH : ST_STROBE;
        end
      end
      ST_WFETCH: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          dat_d   = wdata;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        to_en     = 1'b1;
        // An ack in the expiry cycle still completes the beat.
        if (wbm_ack_i) begin
          rsp_d.beats = rsp_q.beats + BEAT_ONE;
          if (we_q) begin
            state_d = ST_GAP;
          end else begin
            rdata_d = wbm_dat_i;
            state_d = ST_RDRAIN;
          end
        end else if (to_expired) begin
          rsp_d.err = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RDRAIN: begin
        rdata_valid = 1'b1;
        if (rdata_ready) state_d = ST_GAP;
      end
      ST_GAP: begin
        adr_d  = adr_q + STRIDE;
        to_clr = 1'b1;
        if (rsp_q.beats == ({1'b0, len_q} + BEAT_ONE)) begin
          state_d = ST_RESP;
        end else begin
          state_d = we_q ? ST_WFETCH : ST_STROBE;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      len_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      rsp_q   <= rsp_d;
    end
  end

  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rdata     = rdata_q;
  assign rsp_err   = rsp_q.err;
  assign rsp_beats = rsp_q.beats;
  assign busy      = (state_q != ST_IDLE);

endmodule
